// File: rtl/uart_ctrl_pkg.sv
// uart_ctrl_pkg: register offsets, STATUS/CTRL bit positions and TX sequencer state codes
package uart_ctrl_pkg;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;
  localparam int ST_RX_EMPTY = 0;
  localparam int ST_RX_FULL = 1;
  localparam int ST_TX_EMPTY = 2;
  localparam int ST_TX_FULL = 3;
  localparam int ST_TX_ACTIVE = 4;
  localparam int ST_RX_OVERRUN = 5;
  localparam int CTRL_RX_IE = 0;
  localparam int CTRL_TX_IE = 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: DEPTH-entry synchronous FIFO, head on dout, simultaneous push/pop allowed when full
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= do_push ? wp + AW'(1) : wp;
      rp <= do_pop ? rp + AW'(1) : rp;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/uart_ctrl.sv
// uart_ctrl: CPU-bus UART register block with TX/RX FIFOs, TX sequencer and level interrupt
module uart_ctrl
  import uart_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_done,
  input  logic [7:0]  rx_data,
  input  logic        rx_rcv,
  output logic        irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [1:0] state;
  logic rx_empty, rx_full, tx_empty, tx_full, rx_overrun, rx_ie, tx_ie, tx_active;
  logic data_wr, data_rd, stat_wr, ctrl_wr, tx_pop;
  logic [7:0] rx_dout, tx_dout;
  logic [CW-1:0] rx_count, tx_count;
  logic [31:0] status, ctrl;
  logic unused;
  assign data_wr = ready & we & (addr == ADDR_DATA);
  assign data_rd = ready & ~we & (addr == ADDR_DATA);
  assign stat_wr = ready & we & (addr == ADDR_STATUS);
  assign ctrl_wr = ready & we & (addr == ADDR_CTRL);
  assign tx_pop = state == S_LOAD;
  assign tx_start = state == S_LOAD;
  assign tx_active = state != S_IDLE;
  assign irq = (rx_ie & ~rx_empty) | (tx_ie & tx_empty);
  assign unused = ^{wdata[31:8], rx_count, tx_count};
  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst(rst), .push(data_wr), .pop(tx_pop), .din(wdata[7:0]),
    .dout(tx_dout), .empty(tx_empty), .full(tx_full), .count(tx_count)
  );
  uart_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst(rst), .push(rx_rcv), .pop(data_rd), .din(rx_data),
    .dout(rx_dout), .empty(rx_empty), .full(rx_full), .count(rx_count)
  );
  always_comb begin
    status = '0;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_RX_FULL] = rx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_TX_FULL] = tx_full;
    status[ST_TX_ACTIVE] = tx_active;
    status[ST_RX_OVERRUN] = rx_overrun;
    ctrl = '0;
    ctrl[CTRL_RX_IE] = rx_ie;
    ctrl[CTRL_TX_IE] = tx_ie;
    rdata = (~ready | we) ? '0 :
            addr == ADDR_DATA ? {24'b0, rx_empty ? 8'h00 : rx_dout} :
            addr == ADDR_STATUS ? status :
            addr == ADDR_CTRL ? ctrl : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ready <= 1'b0;
      state <= S_IDLE;
      tx_data <= '0;
      rx_overrun <= 1'b0;
      rx_ie <= 1'b0;
      tx_ie <= 1'b0;
    end else begin
      ready <= sel & ~ready;
      state <= state == S_IDLE ? (tx_empty ? S_IDLE : S_LOAD) :
               state == S_LOAD ? S_WAIT : (tx_done ? S_IDLE : S_WAIT);
      if (state == S_IDLE && !tx_empty) tx_data <= tx_dout;
      rx_overrun <= (rx_overrun & ~(stat_wr & wdata[ST_RX_OVERRUN])) | (rx_rcv & rx_full & ~data_rd);
      if (ctrl_wr) begin
        rx_ie <= wdata[CTRL_RX_IE];
        tx_ie <= wdata[CTRL_TX_IE];
      end
    end
  end
endmodule
